xt_hb_arbiter: RTL and testbench

Round-robin arbiter that shares the XT_HB high-speed bus between several masters (RISC-V core data port, DMA, debug). It sits between the masters' request lines and the XT_HB master mux. It issues one registered one-hot grant, holds it for the duration of a transfer, and supports bounded locked (back-to-back) ownership for atomic sequences. Handover between masters costs zero idle cycles.

---
 rtl/xt_hb_arbiter.sv | 165 ++++++++++++++++
 tb/tb_xt_hb_arbiter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/xt_hb_arbiter.sv
// xt_hb_arbiter: round-robin owner arbitration for the XT_HB bus.
// One registered one-hot grant is held for the whole transfer. Ownership
// passes on the edge that completes the transfer, so the bus never idles
// between owners. A locking master may keep the bus for a bounded number
// of back-to-back transfers before the lock is broken.
module xt_hb_arbiter #(
  parameter int MASTER_NUM = 2,
  parameter int MAX_LOCK   = 16,
  parameter int ID_W       = $clog2(MASTER_NUM)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [MASTER_NUM-1:0] req,
  input  logic [MASTER_NUM-1:0] lock,
  input  logic                  slave_done,
  output logic [MASTER_NUM-1:0] grant,
  output logic [ID_W-1:0]       grant_id,
  output logic                  grant_valid,
  output logic                  lock_timeout
);

  // Last count value a locking owner may reach before its lock is broken.
  localparam logic [7:0]      LOCK_LAST = 8'(MAX_LOCK - 1);
  localparam logic [ID_W-1:0] ID_LAST   = ID_W'(MASTER_NUM - 1);

  typedef enum logic {
    ST_IDLE,
    ST_OWNED
  } state_t;

  state_t                r_state, w_state_nxt;
  logic [MASTER_NUM-1:0] r_grant, w_grant_nxt;
  logic [ID_W-1:0]       r_gid, w_gid_nxt;
  logic                  r_valid;
  logic [ID_W-1:0]       r_ptr, w_ptr_nxt;
  logic [7:0]            r_lock_cnt, w_lock_cnt_nxt;
  logic                  r_lock_to, w_lock_to_nxt;

  logic                  w_pick_found;
  logic [ID_W-1:0]       w_pick_id;
  logic [ID_W-1:0]       w_gid_plus;
  logic                  w_req_g;
  logic                  w_lock_g;
  logic                  w_timeout;

  // First requesting master scanning upward from start (modulo MASTER_NUM),
  // optionally skipping one index. Returns {found, index}.
  function automatic logic [ID_W:0] pickNext(
    input logic [MASTER_NUM-1:0] reqVec,
    input logic [ID_W-1:0]       start,
    input logic                  exclEn,
    input logic [ID_W-1:0]       excl
  );
    logic            found;
    logic [ID_W-1:0] sel;
    logic [ID_W-1:0] cur;
    found = 1'b0;
    sel   = '0;
    cur   = start;
    for (int k = 0; k < MASTER_NUM; k++) begin
      if (!found && reqVec[cur] && !(exclEn && (cur == excl))) begin
        found = 1'b1;
        sel   = cur;
      end
      cur = (cur == ID_LAST) ? '0 : cur + 1'b1;
    end
    return {found, sel};
  endfunction

  function automatic logic [MASTER_NUM-1:0] toOneHot(input logic [ID_W-1:0] id);
    logic [MASTER_NUM-1:0] vec;
    vec     = '0;
    vec[id] = 1'b1;
    return vec;
  endfunction

  // Candidate next owner; the current owner is skipped only while one exists.
  always_comb begin
    {w_pick_found, w_pick_id} = pickNext(req, r_ptr, (r_state == ST_OWNED), r_gid);
  end

  assign w_gid_plus = (r_gid == ID_LAST) ? '0 : r_gid + 1'b1;
  assign w_req_g    = req[r_gid];
  assign w_lock_g   = lock[r_gid];

  // Next owner, pointer and lock count from the current owner's situation.
  always_comb begin
    w_state_nxt    = r_state;
    w_grant_nxt    = r_grant;
    w_gid_nxt      = r_gid;
    w_ptr_nxt      = r_ptr;
    w_lock_cnt_nxt = r_lock_cnt;
    w_lock_to_nxt  = 1'b0;
    w_timeout      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_pick_found) begin
          w_state_nxt    = ST_OWNED;
          w_gid_nxt      = w_pick_id;
          w_grant_nxt    = toOneHot(w_pick_id);
          w_lock_cnt_nxt = 8'd0;
        end
      end
      ST_OWNED: begin
        // Nothing moves while the owner's transfer is still in flight.
        if (slave_done || !w_req_g) begin
          if (slave_done && w_lock_g && w_req_g && (r_lock_cnt < LOCK_LAST)) begin
            w_lock_cnt_nxt = r_lock_cnt + 8'd1;
          end else begin
            // Abort (no slave_done) can never count as a lock timeout.
            w_timeout     = slave_done && w_lock_g && (r_lock_cnt == LOCK_LAST);
            w_lock_to_nxt = w_timeout;
            if (w_pick_found) begin
              w_gid_nxt      = w_pick_id;
              w_grant_nxt    = toOneHot(w_pick_id);
              w_ptr_nxt      = w_gid_plus;
              w_lock_cnt_nxt = 8'd0;
            end else if (w_timeout) begin
              w_ptr_nxt      = w_gid_plus;
              w_lock_cnt_nxt = 8'd0;
            end else if (!w_req_g) begin
              w_state_nxt    = ST_IDLE;
              w_gid_nxt      = '0;
              w_grant_nxt    = '0;
              w_ptr_nxt      = w_gid_plus;
              w_lock_cnt_nxt = 8'd0;
            end
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_grant_nxt = '0;
        w_gid_nxt   = '0;
      end
    endcase
  end

  // State register; reset drops the grant immediately, without waiting for a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_grant    <= '0;
      r_gid      <= '0;
      r_valid    <= 1'b0;
      r_ptr      <= '0;
      r_lock_cnt <= 8'd0;
      r_lock_to  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_grant    <= w_grant_nxt;
      r_gid      <= w_gid_nxt;
      r_valid    <= |w_grant_nxt;
      r_ptr      <= w_ptr_nxt;
      r_lock_cnt <= w_lock_cnt_nxt;
      r_lock_to  <= w_lock_to_nxt;
    end
  end

  assign grant        = r_grant;
  assign grant_id     = r_gid;
  assign grant_valid  = r_valid;
  assign lock_timeout = r_lock_to;

endmodule

// File: tb/tb_xt_hb_arbiter.sv
// Testbench for xt_hb_arbiter with four masters and a lock bound of 4.
// Directed vector table, hand sequences around reset, then random traffic
// compared against an owner/pointer model built from the arbitration rules.
module tb_xt_hb_arbiter;

  localparam int N    = 4;
  localparam int MAXL = 4;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] lock;
  logic       slave_done;
  logic [3:0] grant;
  logic [1:0] grantId;
  logic       grantValid;
  logic       lockTimeout;

  int nCompared   = 0;
  int nMismatched = 0;

  typedef struct packed {
    logic [3:0] req;
    logic [3:0] lock;
    logic       done;
    logic [3:0] eGrant;
    logic [1:0] eId;
    logic       eValid;
    logic       eTo;
  } vec_t;

  vec_t tbl[$];

  // Model state: owner index (-1 when the bus is idle), pointer, lock count.
  int mOwner;
  int mPtr;
  int mCnt;
  bit mTo;

  logic [3:0] rndReq;
  logic [3:0] rndLock;
  logic       rndDone;

  xt_hb_arbiter #(
    .MASTER_NUM(N),
    .MAX_LOCK  (MAXL)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .lock        (lock),
    .slave_done  (slave_done),
    .grant       (grant),
    .grant_id    (grantId),
    .grant_valid (grantValid),
    .lock_timeout(lockTimeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] time limit");
  end

  task automatic addVec(input logic [3:0] r, input logic [3:0] l, input logic d,
                        input logic [3:0] g, input logic [1:0] id, input logic v,
                        input logic t);
    vec_t e;
    e = '{req: r, lock: l, done: d, eGrant: g, eId: id, eValid: v, eTo: t};
    tbl.push_back(e);
  endtask

  task automatic applyStimulus(input logic [3:0] r, input logic [3:0] l, input logic d);
    @(negedge clk);
    req        = r;
    lock       = l;
    slave_done = d;
  endtask

  task automatic checkOutput(input string name, input logic [3:0] eg, input logic [1:0] eid,
                             input logic ev, input logic et);
    nCompared++;
    if (grant !== eg) begin
      nMismatched++;
      $display("[TB] FAIL %s grant: got %b, expected %b", name, grant, eg);
    end
    nCompared++;
    if (grantId !== eid) begin
      nMismatched++;
      $display("[TB] FAIL %s grant_id: got %0d, expected %0d", name, grantId, eid);
    end
    nCompared++;
    if (grantValid !== ev) begin
      nMismatched++;
      $display("[TB] FAIL %s grant_valid: got %b, expected %b", name, grantValid, ev);
    end
    nCompared++;
    if (lockTimeout !== et) begin
      nMismatched++;
      $display("[TB] FAIL %s lock_timeout: got %b, expected %b", name, lockTimeout, et);
    end
  endtask

  function automatic int rrPick(input logic [3:0] r, input int from, input int excl);
    for (int k = 0; k < N; k++) begin
      int i;
      i = (from + k) % N;
      if (r[i] && i != excl) return i;
    end
    return -1;
  endfunction

  task automatic resetModel();
    mOwner = -1;
    mPtr   = 0;
    mCnt   = 0;
    mTo    = 1'b0;
  endtask

  // One clock edge of the arbitration rules, using the inputs seen at that edge.
  task automatic modelStep(input logic [3:0] r, input logic [3:0] l, input logic d);
    int g;
    int p;
    mTo = 1'b0;
    if (mOwner < 0) begin
      p = rrPick(r, mPtr, -1);
      if (p >= 0) begin
        mOwner = p;
        mCnt   = 0;
      end
    end else begin
      g = mOwner;
      if (!d && r[g]) begin
        // transfer still running
      end else if (!d) begin
        p      = rrPick(r, mPtr, g);
        mPtr   = (g + 1) % N;
        mCnt   = 0;
        mOwner = p;
      end else if (l[g] && r[g] && mCnt < MAXL - 1) begin
        mCnt = mCnt + 1;
      end else if (l[g] && mCnt == MAXL - 1) begin
        mTo    = 1'b1;
        p      = rrPick(r, mPtr, g);
        mPtr   = (g + 1) % N;
        mCnt   = 0;
        mOwner = (p >= 0) ? p : g;
      end else begin
        p = rrPick(r, mPtr, g);
        if (p >= 0) begin
          mPtr   = (g + 1) % N;
          mCnt   = 0;
          mOwner = p;
        end else if (!r[g]) begin
          mPtr   = (g + 1) % N;
          mCnt   = 0;
          mOwner = -1;
        end
      end
    end
  endtask

  initial begin
    logic [3:0] eg;
    logic [1:0] eid;
    req        = 4'b0011;
    lock       = 4'b0000;
    slave_done = 1'b0;
    rst_n      = 1'b0;

    // Directed table: from reset, pointer and lock count tracked by hand.
    addVec(4'b0011, 4'b0000, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0);
    addVec(4'b0011, 4'b0000, 1'b1, 4'b0010, 2'd1, 1'b1, 1'b0);
    repeat (5) addVec(4'b0011, 4'b0000, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0);
    addVec(4'b0011, 4'b0000, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b0);
    repeat (3) addVec(4'b0011, 4'b0001, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b0);
    addVec(4'b0011, 4'b0001, 1'b1, 4'b0010, 2'd1, 1'b1, 1'b1);
    addVec(4'b1111, 4'b0000, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b0);
    addVec(4'b1111, 4'b0000, 1'b1, 4'b1000, 2'd3, 1'b1, 1'b0);
    addVec(4'b1111, 4'b0000, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b0);
    addVec(4'b1111, 4'b0000, 1'b1, 4'b0010, 2'd1, 1'b1, 1'b0);
    repeat (2) begin
      repeat (3) addVec(4'b0010, 4'b0010, 1'b1, 4'b0010, 2'd1, 1'b1, 1'b0);
      addVec(4'b0010, 4'b0010, 1'b1, 4'b0010, 2'd1, 1'b1, 1'b1);
    end
    addVec(4'b0000, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0);
    addVec(4'b0101, 4'b0000, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0);
    addVec(4'b0000, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0);
    addVec(4'b0001, 4'b0010, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0);
    addVec(4'b0011, 4'b0010, 1'b1, 4'b0010, 2'd1, 1'b1, 1'b0);
    addVec(4'b0101, 4'b0000, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0);
    addVec(4'b0000, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0);

    $display("[TB] reset with requests pending");
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_state", 4'b0000, 2'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] directed table, %0d vectors", tbl.size());
    foreach (tbl[i]) begin
      applyStimulus(tbl[i].req, tbl[i].lock, tbl[i].done);
      @(posedge clk);
      #1;
      checkOutput($sformatf("vec%0d", i), tbl[i].eGrant, tbl[i].eId, tbl[i].eValid, tbl[i].eTo);
    end

    $display("[TB] reset mid-grant");
    applyStimulus(4'b0001, 4'b0000, 1'b0);
    @(posedge clk);
    #1;
    checkOutput("pre_reset_grant", 4'b0001, 2'd0, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_clear", 4'b0000, 2'd0, 1'b0, 1'b0);
    applyStimulus(4'b1010, 4'b0000, 1'b0);
    @(posedge clk);
    #1;
    checkOutput("reset_hold", 4'b0000, 2'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("rearb_from_ptr0", 4'b0010, 2'd1, 1'b1, 1'b0);

    $display("[TB] random traffic against the reference model");
    applyStimulus(4'b0000, 4'b0000, 1'b0);
    rst_n = 1'b0;
    resetModel();
    @(negedge clk);
    rst_n  = 1'b1;
    rndReq = 4'b0000;
    for (int c = 0; c < 3000; c++) begin
      rndReq  = rndReq ^ (4'($urandom) & 4'($urandom));
      rndLock = rndReq & (4'($urandom) | 4'($urandom));
      rndDone = ($urandom_range(0, 2) != 0);
      applyStimulus(rndReq, rndLock, rndDone);
      @(posedge clk);
      modelStep(rndReq, rndLock, rndDone);
      #1;
      eg  = (mOwner < 0) ? 4'b0000 : 4'(1 << mOwner);
      eid = (mOwner < 0) ? 2'd0 : 2'(mOwner);
      checkOutput($sformatf("rand%0d", c), eg, eid, (mOwner >= 0), mTo);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
